// File: rtl/alu_response_checker.sv
// ---------------------------------------------------------------------------
// alu_response_checker
//
// Analysis end of the 4-bit ALU trojan-detection flow. Every vector accepted
// in RUN is compared against a built-in golden ALU. The block counts accepted
// vectors and mismatches, records which opcodes failed, and captures the
// first failing vector. It reports pass/fail once SWEEP_LEN vectors have been
// checked.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              pulse: begin a sweep (IDLE only)
//   clear              pulse: zero statistics and return to IDLE (any state)
//   in_valid           A/B/op/dut_result form a vector to check
//   A, B, op           stimulus applied to the ALU under test
//   dut_result         result returned by the ALU under test
//   busy, done, pass   status (pass = DONE with zero mismatches)
//   trojan_detected    sticky, set on the first mismatch
//   vec_count          vectors accepted in this sweep
//   mismatch_count     mismatching vectors, saturating at 2047
//   op_fail_mask       bit n set if any op==n vector mismatched
//   first_fail_vec/got/exp  {op,A,B}, DUT result and golden result of the
//                           first mismatch
// ---------------------------------------------------------------------------
module alu_response_checker #(
    parameter int SWEEP_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    input  logic [1:0]  op,
    input  logic [3:0]  dut_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        trojan_detected,
    output logic [10:0] vec_count,
    output logic [10:0] mismatch_count,
    output logic [3:0]  op_fail_mask,
    output logic [9:0]  first_fail_vec,
    output logic [3:0]  first_fail_got,
    output logic [3:0]  first_fail_exp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0] LAST_IDX  = 11'(SWEEP_LEN - 1);
    localparam logic [10:0] MISM_SAT  = 11'h7FF;

    state_t      state_q;
    logic        busy_q, done_q;
    logic        trojan_q, trojan_d;
    logic [10:0] vec_count_q, vec_count_d;
    logic [10:0] mism_count_q, mism_count_d;
    logic [3:0]  op_mask_q, op_mask_d;
    logic [9:0]  ff_vec_q, ff_vec_d;
    logic [3:0]  ff_got_q, ff_got_d;
    logic [3:0]  ff_exp_q, ff_exp_d;

    logic [3:0]  golden;
    logic        accept;
    logic        mismatch;
    logic        zero_stats;
    logic        last_accept;

    function automatic logic [3:0] golden_alu(input logic [1:0] o,
                                              input logic [3:0] a,
                                              input logic [3:0] b);
        case (o)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign golden      = golden_alu(op, A, B);
    // clear has priority over everything, including a vector on the same edge
    assign accept      = (state_q == S_RUN) && in_valid && !clear;
    assign mismatch    = accept && (dut_result != golden);
    assign zero_stats  = clear || ((state_q == S_IDLE) && start);
    assign last_accept = accept && (vec_count_q == LAST_IDX);

    always_comb begin
        vec_count_d  = vec_count_q;
        mism_count_d = mism_count_q;
        op_mask_d    = op_mask_q;
        trojan_d     = trojan_q;
        ff_vec_d     = ff_vec_q;
        ff_got_d     = ff_got_q;
        ff_exp_d     = ff_exp_q;
        if (zero_stats) begin
            vec_count_d  = '0;
            mism_count_d = '0;
            op_mask_d    = '0;
            trojan_d     = 1'b0;
            ff_vec_d     = '0;
            ff_got_d     = '0;
            ff_exp_d     = '0;
        end else if (accept) begin
            vec_count_d = vec_count_q + 11'd1;
            if (mismatch) begin
                if (mism_count_q != MISM_SAT) begin
                    mism_count_d = mism_count_q + 11'd1;
                end
                op_mask_d[op] = 1'b1;
                trojan_d      = 1'b1;
                // capture only the first failure of the sweep
                if (!trojan_q) begin
                    ff_vec_d = {op, A, B};
                    ff_got_d = dut_result;
                    ff_exp_d = golden;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count_q  <= '0;
            mism_count_q <= '0;
            op_mask_q    <= '0;
            trojan_q     <= 1'b0;
            ff_vec_q     <= '0;
            ff_got_q     <= '0;
            ff_exp_q     <= '0;
        end else begin
            vec_count_q  <= vec_count_d;
            mism_count_q <= mism_count_d;
            op_mask_q    <= op_mask_d;
            trojan_q     <= trojan_d;
            ff_vec_q     <= ff_vec_d;
            ff_got_q     <= ff_got_d;
            ff_exp_q     <= ff_exp_d;
        end
    end

    // Control FSM with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !clear) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (clear) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_accept) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = done_q && (mism_count_q == '0);
    assign trojan_detected = trojan_q;
    assign vec_count       = vec_count_q;
    assign mismatch_count  = mism_count_q;
    assign op_fail_mask    = op_mask_q;
    assign first_fail_vec  = ff_vec_q;
    assign first_fail_got  = ff_got_q;
    assign first_fail_exp  = ff_exp_q;

endmodule
